// File: rtl/sha3_pkg.sv
// sha3_pkg -- shared constants, types and helpers for the SHA-3 padding block.
//   SHA3_DSEP   : domain-separation byte placed right after the message (0x06)
//   SHA3_PADEND : bit set in the last byte of the final rate block (0x80)
//   state_t     : padder state encoding
//   rate_bits() : Keccak-f[1600] rate for a given digest width
package sha3_pkg;

    localparam logic [7:0] SHA3_DSEP   = 8'h06;
    localparam logic [7:0] SHA3_PADEND = 8'h80;

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        EMIT     = 2'd1,
        EMIT_PAD = 2'd2
    } state_t;

    function automatic int rate_bits(input int d);
        return 1600 - 2 * d;
    endfunction

endpackage

// File: rtl/sha3_pad.sv
// sha3_pad -- collects message bytes into R-bit rate blocks and applies
// SHA-3 padding (0x06 ... 0x80) to the final block.
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid/in_ready   : byte-stream handshake, in_data byte, in_last marks end
//   blk_valid/blk_ready : block handshake to the keccak core
//   blk_data            : padded rate block, byte 0 in the most significant byte
//   blk_last            : final block of the message
// blk_data feeds the keccak message input directly; blk_valid && blk_ready
// is the keccak enable.
module sha3_pad
    import sha3_pkg::*;
#(
    parameter  int D = 512,
    localparam int R = rate_bits(D)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [R-1:0] blk_data,
    output logic         blk_last
);

    localparam int NB = R / 8;
    localparam int CW = $clog2(NB);
    localparam int SW = $clog2(R);

    // Stand-alone pad block used when the message ends exactly on a block boundary.
    localparam logic [R-1:0] PAD_BLK = {SHA3_DSEP, {(R-16){1'b0}}, SHA3_PADEND};

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            pad_pend;
    logic            accept;
    logic            fire;
    logic            last_slot;
    logic [SW-1:0]   sh_data;
    logic [SW-1:0]   sh_sep;
    logic [R-1:0]    fill_data;

    assign in_ready  = (state == FILL);
    assign blk_valid = (state != FILL);
    assign accept    = in_valid && in_ready;
    assign fire      = blk_valid && blk_ready;
    assign last_slot = (cnt == CW'(NB - 1));

    // Unwritten bytes of blk_data are always zero (cleared after each block),
    // so new bytes and pad bytes can simply be OR-ed into place. When the
    // separator lands in byte NB-1 the OR yields 0x86.
    always_comb begin
        sh_data   = SW'(R - 8 - 8 * int'(cnt));
        sh_sep    = SW'(R - 16 - 8 * int'(cnt));
        fill_data = blk_data | ({{(R-8){1'b0}}, in_data} << sh_data);
        if (in_last && !last_slot) begin
            fill_data = fill_data
                      | ({{(R-8){1'b0}}, SHA3_DSEP} << sh_sep)
                      | {{(R-8){1'b0}}, SHA3_PADEND};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FILL;
            cnt      <= '0;
            pad_pend <= 1'b0;
            blk_data <= '0;
            blk_last <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        blk_data <= fill_data;
                        if (last_slot || in_last) begin
                            state    <= EMIT;
                            blk_last <= in_last && !last_slot;
                            // Full block ended the message: padding needs a block of its own.
                            pad_pend <= in_last && last_slot;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                EMIT: begin
                    if (fire) begin
                        cnt <= '0;
                        if (pad_pend) begin
                            state    <= EMIT_PAD;
                            blk_data <= PAD_BLK;
                            blk_last <= 1'b1;
                            pad_pend <= 1'b0;
                        end else begin
                            state    <= FILL;
                            blk_data <= '0;
                            blk_last <= 1'b0;
                        end
                    end
                end
                EMIT_PAD: begin
                    if (fire) begin
                        state    <= FILL;
                        cnt      <= '0;
                        blk_data <= '0;
                        blk_last <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha3_pad.sv
// tb_sha3_pad -- scoreboard bench for sha3_pad at D=512 (NB=72) and D=256 (NB=136).
// Expected blocks are built from each message when it is driven and compared
// when the DUT hands a block to the consumer.
module tb_sha3_pad;

    typedef struct {
        logic [1087:0] data;   // byte k at [1087-8k -: 8]
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    in_valid, in_ready, in_last, blk_valid, blk_ready, blk_last;
    logic [7:0]    in_data [2];
    logic [575:0]  bd0;
    logic [1087:0] bd1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    sha3_pad #(.D(512)) u_512 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
        .blk_valid(blk_valid[0]), .blk_ready(blk_ready[0]), .blk_data(bd0), .blk_last(blk_last[0])
    );

    sha3_pad #(.D(256)) u_256 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
        .blk_valid(blk_valid[1]), .blk_ready(blk_ready[1]), .blk_data(bd1), .blk_last(blk_last[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Compare the block being handed over this cycle against the queue head.
    task automatic mon(input int sel);
        logic [1087:0] obs;
        exp_t          e;
        int            nw;
        bit            empty;
        obs   = (sel == 0) ? {bd0, 512'b0} : bd1;
        nw    = (sel == 0) ? 9 : 17;
        empty = (sel == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (blk_valid[sel] && blk_ready[sel]) begin
            check("in_ready_during_emit", 64'(in_ready[sel]), 64'd0);
            if (empty) begin
                check("unexpected_block", 64'd1, 64'd0);
            end else begin
                e = (sel == 0) ? q0.pop_front() : q1.pop_front();
                for (int w = 0; w < nw; w++)
                    check($sformatf("blk_data%0d_w%0d", sel, w),
                          64'(obs >> (1024 - 64 * w)), 64'(e.data >> (1024 - 64 * w)));
                check($sformatf("blk_last%0d", sel), 64'(blk_last[sel]), 64'(e.last));
            end
        end
    endtask

    always @(negedge clk) begin #1; if (!reset) mon(0); end
    always @(negedge clk) begin #1; if (!reset) mon(1); end

    task automatic drive_byte(input int sel, input logic [7:0] v, input logic last);
        int t = 0;
        @(negedge clk);
        in_valid[sel] = 1'b1;
        in_data[sel]  = v;
        in_last[sel]  = last;
        while (!in_ready[sel] && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) check("in_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
    endtask

    task automatic end_drive(input int sel);
        @(negedge clk);
        in_valid[sel] = 1'b0;
        in_last[sel]  = 1'b0;
    endtask

    // Message byte i = seed + i*step; expected blocks derived from the SHA-3 pad rule.
    task automatic send_msg(input int sel, input int len, input int seed, input int step);
        logic [7:0] msg[$];
        exp_t       e;
        int         nb, pos, rem;
        nb = (sel == 0) ? 72 : 136;
        for (int i = 0; i < len; i++) msg.push_back(8'(seed + i * step));
        pos = 0;
        while (len - pos >= nb) begin
            e.data = '0;
            e.last = 1'b0;
            for (int k = 0; k < nb; k++) e.data |= 1088'(msg[pos + k]) << (1080 - 8 * k);
            pos += nb;
            if (sel == 0) q0.push_back(e); else q1.push_back(e);
        end
        rem    = len - pos;
        e.data = '0;
        e.last = 1'b1;
        for (int k = 0; k < rem; k++) e.data |= 1088'(msg[pos + k]) << (1080 - 8 * k);
        e.data |= 1088'(8'h06) << (1080 - 8 * rem);
        e.data |= 1088'(8'h80) << (1080 - 8 * (nb - 1));
        if (sel == 0) q0.push_back(e); else q1.push_back(e);
        for (int i = 0; i < len; i++) drive_byte(sel, msg[i], i == len - 1);
        end_drive(sel);
    endtask

    task automatic drain(input int sel);
        int t = 0;
        while (((sel == 0) ? q0.size() : q1.size()) != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check("drain_timeout", 64'd0, 64'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    logic [575:0] snap;

    initial begin
        reset      = 1'b1;
        in_valid   = '0;
        in_last    = '0;
        in_data[0] = '0;
        in_data[1] = '0;
        blk_ready  = 2'b11;

        // Reset state
        repeat (2) @(negedge clk);
        #2;
        for (int s = 0; s < 2; s++) begin
            check("rst_in_ready",  64'(in_ready[s]),  64'd1);
            check("rst_blk_valid", 64'(blk_valid[s]), 64'd0);
            check("rst_blk_last",  64'(blk_last[s]),  64'd0);
        end
        check("rst_blk_data0", 64'(|bd0), 64'd0);
        check("rst_blk_data1", 64'(|bd1), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // "abc", 71 bytes (0x86 end), 72 bytes (separate pad block)
        send_msg(0, 3, 'h61, 1);    drain(0);
        send_msg(0, 71, 'h10, 13);  drain(0);
        send_msg(0, 72, 'h22, 7);   drain(0);

        // NB=136: 200 bytes -> sep at byte 64 of block 2; plus boundaries
        send_msg(1, 200, 'h05, 3);  drain(1);
        send_msg(1, 135, 'h31, 11); drain(1);
        send_msg(1, 272, 'h44, 5);  drain(1);
        send_msg(1, 1, 'hff, 1);    drain(1);
        for (int r = 0; r < 3; r++) begin
            send_msg(1, int'($urandom_range(1, 300)), int'($urandom_range(0, 255)), 13);
            drain(1);
        end

        // Back-pressure: consumer stalls for 5 cycles on a full data block
        blk_ready[0] = 1'b0;
        send_msg(0, 72, 'h09, 17);
        snap = bd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            check("stall_blk_valid", 64'(blk_valid[0]), 64'd1);
            check("stall_in_ready",  64'(in_ready[0]),  64'd0);
            check("stall_hold_data", 64'(bd0 == snap),  64'd1);
            check("stall_hold_last", 64'(blk_last[0]),  64'd0);
        end
        @(negedge clk);
        blk_ready[0] = 1'b1;
        drain(0);
        send_msg(0, 5, 'h70, 1);    drain(0);

        // Reset after 10 bytes of an unfinished message, then "abc"
        for (int i = 0; i < 10; i++) drive_byte(0, 8'(i + 'h40), 1'b0);
        end_drive(0);
        reset = 1'b1;
        #2;
        check("midrst_in_ready",  64'(in_ready[0]),  64'd1);
        check("midrst_blk_valid", 64'(blk_valid[0]), 64'd0);
        check("midrst_blk_data",  64'(|bd0),         64'd0);
        @(negedge clk);
        reset = 1'b0;
        send_msg(0, 3, 'h61, 1);    drain(0);

        drain(1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
